cpu_controller: RTL and testbench
=================================

// Module: cpu_controller
// PURPOSE
// - Instruction-sequencing FSM for the 8-bit accumulator CPU; drives every datapath strobe.
// - Walks an 8-phase cycle per instruction and decodes opcode[2:0] and the accumulator zero flag.
// - Outputs: the instruction-register load strobe, the PC inc/load, the address-mux select, memory rd/wr, the AC load, and the data-bus enable.
// PARAMETERS
// - OP_W     3   opcode width; equals `DATA_WIDTH-`ADDR_WIDTH
// - PHASE_W  4   state register width (8 run phases + HALTED)
// PORTS
// - clk      in   1     clock, rising edge
// - rst      in   1     reset, asynchronous, active-high
// - opcode   in   OP_W  current instruction opcode from instruction register
// - zero     in   1     accumulator==0 flag from ALU
// - sel      out  1     address mux: 1=PC, 0=IR operand
// - rd       out  1     memory read enable
// - ld_ir    out  1     instruction register load
// - inc_pc   out  1     PC increment
// - ld_pc    out  1     PC load from IR operand (jump)
// - ld_ac    out  1     accumulator load from ALU
// - wr       out  1     memory write strobe
// - data_e   out  1     drive AC onto data bus
// - halt     out  1     CPU halted indicator
// - phase    out  PHASE_W current state (debug/verification)
// BEHAVIOUR
// - Opcodes: HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7; ALUOP = ADD|AND|XOR|LDA.
// - States: INST_ADDR=0 INST_FETCH=1 INST_LOAD=2 IDLE=3 OP_ADDR=4 OP_FETCH=5 ALU_OP=6 STORE=7 HALTED=8.
// - Transitions: 0->1->2->3->4->5->6->7->0, one per clk.
// - In OP_ADDR with opcode==HLT, the next state is HALTED. HALTED is left only by rst.
// - Outputs are a combinational decode of phase, opcode and zero. All unlisted outputs are 0.
//   INST_ADDR:  sel
//   INST_FETCH: sel rd
//   INST_LOAD:  sel rd ld_ir
//   IDLE:       sel rd ld_ir
//   OP_ADDR:    inc_pc=(opcode!=HLT); halt=(opcode==HLT)
//   OP_FETCH:   rd=ALUOP
//   ALU_OP:     rd=ALUOP; inc_pc=(SKZ&&zero); ld_pc=JMP; data_e=STO
//   STORE:      rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; wr=STO; data_e=STO
//   HALTED:     halt=1 only
// - Latency: one instruction = 8 clk. The IR captures on the edge ending INST_LOAD and holds through IDLE.
// - opcode is sampled only in states 4..7. Its value in states 0..3 does not affect outputs.
// - zero is sampled only in ALU_OP.
// - SKZ with zero=0 is a no-op; the PC advances only via the OP_ADDR inc_pc.
// - Reset (any time, including mid-instruction): phase=INST_ADDR asynchronously.
//   Outputs follow immediately: sel=1, all others 0, halt=0, phase=0.
// - Unreachable phase encodings 9..15 go to INST_ADDR on the next clk, with all outputs 0.
// CONFIGURATION
// - CTRL_SINGLE_STEP_EN defined: adds input `step` (1 bit), sampled on clk.
//   - In INST_ADDR, advance to INST_FETCH only when step=1; otherwise hold INST_ADDR, with sel=1.
//   - Other states advance unconditionally. A step held high runs at full speed.
//   - HALTED ignores step.
// - CTRL_SINGLE_STEP_EN undefined: no step port; INST_ADDR always advances.
// TESTING
// - Reset: assert rst mid-ALU_OP -> phase=0, sel=1, all other strobes 0, within the same cycle.
// - LDA, opcode=5: phases 0..7 in 8 clk -> ld_ir in phases 2,3; inc_pc in phase 4; rd in 5,6,7; ld_ac only in phase 7.
// - STO, opcode=6: -> data_e in phases 6,7; wr only in phase 7; rd=0 and ld_ac=0 in phases 5..7.
// - JMP, opcode=7: -> ld_pc=1 in phases 6,7; inc_pc=1 only in phase 4.
// - SKZ, opcode=1:
//   - zero=1 -> inc_pc=1 in phase 6 (two increments per instruction).
//   - zero=0 -> inc_pc only in phase 4.
// - HLT, opcode=0: at phase 4, halt=1 and inc_pc=0 -> phase=8 next; stays 8 for 20 clk with halt=1 for any opcode/zero; rst -> phase 0.
// - CTRL_SINGLE_STEP_EN: step=0 for 5 clk -> phase stays 0. One-clk step pulse -> exactly one instruction, then back to phase 0 waiting.

Source files
------------

// File: rtl/cpu_controller_if.sv
// Controller <-> datapath strobe bundle for the 8-bit accumulator CPU.
// step exists only when CTRL_SINGLE_STEP_EN is defined.
interface cpu_controller_if #(
    parameter int OP_W    = 3,
    parameter int PHASE_W = 4
);
    logic [OP_W-1:0]    opcode;
    logic               zero;
`ifdef CTRL_SINGLE_STEP_EN
    logic               step;
`endif
    logic               sel;
    logic               rd;
    logic               ld_ir;
    logic               inc_pc;
    logic               ld_pc;
    logic               ld_ac;
    logic               wr;
    logic               data_e;
    logic               halt;
    logic [PHASE_W-1:0] phase;

    modport master (
        input  opcode, zero,
`ifdef CTRL_SINGLE_STEP_EN
        input  step,
`endif
        output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
    );

    modport slave (
        output opcode, zero,
`ifdef CTRL_SINGLE_STEP_EN
        output step,
`endif
        input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
    );
endinterface

// File: rtl/cpu_controller.sv
// Purpose: 8-phase instruction sequencer; decodes phase/opcode/zero into datapath strobes.
// Latency: 8 clk per instruction, strobes combinational from phase. Backpressure: none, except
// CTRL_SINGLE_STEP_EN adds bus.step, which gates leaving INST_ADDR.
module cpu_controller #(
    parameter int OP_W    = 3,
    parameter int PHASE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    cpu_controller_if.master  bus
);
    typedef enum logic [PHASE_W-1:0] {
        INST_ADDR  = PHASE_W'(0),
        INST_FETCH = PHASE_W'(1),
        INST_LOAD  = PHASE_W'(2),
        IDLE       = PHASE_W'(3),
        OP_ADDR    = PHASE_W'(4),
        OP_FETCH   = PHASE_W'(5),
        ALU_OP     = PHASE_W'(6),
        STORE      = PHASE_W'(7),
        HALTED     = PHASE_W'(8)
    } state_t;

    localparam logic [OP_W-1:0] OP_HLT = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SKZ = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
    localparam logic [OP_W-1:0] OP_LDA = OP_W'(5);
    localparam logic [OP_W-1:0] OP_STO = OP_W'(6);
    localparam logic [OP_W-1:0] OP_JMP = OP_W'(7);

    state_t phase_q;
    state_t phase_d;
    logic   alu_op;
    logic   is_hlt;
    logic   is_skz;
    logic   is_sto;
    logic   is_jmp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= INST_ADDR;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        alu_op = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                 (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);
        is_hlt = (bus.opcode == OP_HLT);
        is_skz = (bus.opcode == OP_SKZ);
        is_sto = (bus.opcode == OP_STO);
        is_jmp = (bus.opcode == OP_JMP);
    end

    always_comb begin
        phase_d    = INST_ADDR;
        bus.sel    = 1'b0;
        bus.rd     = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.wr     = 1'b0;
        bus.data_e = 1'b0;
        bus.halt   = 1'b0;
        bus.phase  = phase_q;

        case (phase_q)
            INST_ADDR: begin
                bus.sel = 1'b1;
`ifdef CTRL_SINGLE_STEP_EN
                phase_d = bus.step ? INST_FETCH : INST_ADDR;
`else
                phase_d = INST_FETCH;
`endif
            end
            INST_FETCH: begin
                bus.sel = 1'b1;
                bus.rd  = 1'b1;
                phase_d = INST_LOAD;
            end
            INST_LOAD: begin
                bus.sel   = 1'b1;
                bus.rd    = 1'b1;
                bus.ld_ir = 1'b1;
                phase_d   = IDLE;
            end
            IDLE: begin
                // ld_ir stays high so the IR holds its freshly captured value
                bus.sel   = 1'b1;
                bus.rd    = 1'b1;
                bus.ld_ir = 1'b1;
                phase_d   = OP_ADDR;
            end
            OP_ADDR: begin
                bus.inc_pc = !is_hlt;
                bus.halt   = is_hlt;
                phase_d    = is_hlt ? HALTED : OP_FETCH;
            end
            OP_FETCH: begin
                bus.rd  = alu_op;
                phase_d = ALU_OP;
            end
            ALU_OP: begin
                // SKZ on zero skips the next word with a second PC increment
                bus.rd     = alu_op;
                bus.inc_pc = is_skz && bus.zero;
                bus.ld_pc  = is_jmp;
                bus.data_e = is_sto;
                phase_d    = STORE;
            end
            STORE: begin
                bus.rd     = alu_op;
                bus.ld_ac  = alu_op;
                bus.ld_pc  = is_jmp;
                bus.wr     = is_sto;
                bus.data_e = is_sto;
                phase_d    = INST_ADDR;
            end
            HALTED: begin
                bus.halt = 1'b1;
                phase_d  = HALTED;
            end
            default: begin
                phase_d = INST_ADDR;
            end
        endcase
    end
endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: per-phase strobe vectors for each opcode class,
// async reset, halt behaviour and (when CTRL_SINGLE_STEP_EN is defined) single-step gating.
module tb_cpu_controller;
    // strobe vector layout: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
    localparam logic [8:0] S  = 9'h100;
    localparam logic [8:0] R  = 9'h080;
    localparam logic [8:0] IR = 9'h040;
    localparam logic [8:0] IP = 9'h020;
    localparam logic [8:0] LP = 9'h010;
    localparam logic [8:0] LA = 9'h008;
    localparam logic [8:0] W  = 9'h004;
    localparam logic [8:0] DE = 9'h002;
    localparam logic [8:0] H  = 9'h001;
    localparam logic [8:0] Z  = 9'h000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cpu_controller_if #(.OP_W(3), .PHASE_W(4)) bus ();

    cpu_controller #(.OP_W(3), .PHASE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] strobes();
        return {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
                bus.ld_ac, bus.wr, bus.data_e, bus.halt};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs n phases from INST_ADDR; e4..e7 are the opcode-dependent strobes for phases 4..7.
    task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                             input int n, input logic [8:0] e4, input logic [8:0] e5,
                             input logic [8:0] e6, input logic [8:0] e7);
        logic [8:0] e [8];
        e[0] = S;      e[1] = S | R;  e[2] = S | R | IR;  e[3] = S | R | IR;
        e[4] = e4;     e[5] = e5;     e[6] = e6;          e[7] = e7;
        for (int i = 0; i < n; i++) begin
            // opcode is don't-care while the IR is being fetched
            bus.opcode = (i < 4) ? 3'($urandom_range(7, 0)) : op;
            bus.zero   = z;
            #1;
            chk($sformatf("%s_phase%0d", name, i), 16'(bus.phase), 16'(i));
            chk($sformatf("%s_strobes%0d", name, i), 16'(strobes()), 16'(e[i]));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input string name);
        #2;
        rst = 1'b1;
        #1;
        chk({name, "_rst_phase"}, 16'(bus.phase), 16'd0);
        chk({name, "_rst_strobes"}, 16'(strobes()), 16'(S));
        #2;
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.opcode = 3'd0;
        bus.zero   = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
        bus.step   = 1'b1;
`endif
        #12;
        rst = 1'b0;
        #1;
        chk("reset_phase", 16'(bus.phase), 16'd0);
        chk("reset_strobes", 16'(strobes()), 16'(S));

        run_instr("lda",   3'd5, 1'b0, 8, IP, R, R, R | LA);
        run_instr("add",   3'd2, 1'b1, 8, IP, R, R, R | LA);
        run_instr("sto",   3'd6, 1'b0, 8, IP, Z, DE, W | DE);
        run_instr("jmp",   3'd7, 1'b0, 8, IP, Z, LP, LP);
        run_instr("skz_z1", 3'd1, 1'b1, 8, IP, Z, IP, Z);
        run_instr("skz_z0", 3'd1, 1'b0, 8, IP, Z, Z, Z);
        chk("wrap_phase", 16'(bus.phase), 16'd0);

        // reset asserted mid ALU_OP must take effect before the next edge
        run_instr("xor_pre_rst", 3'd4, 1'b0, 6, IP, R, R, R | LA);
        chk("alu_op_phase", 16'(bus.phase), 16'd6);
        chk("alu_op_strobes", 16'(strobes()), 16'(R));
        do_reset("mid_alu");

        run_instr("hlt", 3'd0, 1'b0, 5, H, Z, Z, Z);
        for (int i = 0; i < 20; i++) begin
            bus.opcode = 3'($urandom_range(7, 0));
            bus.zero   = 1'($urandom_range(1, 0));
            #1;
            chk($sformatf("halted_phase%0d", i), 16'(bus.phase), 16'd8);
            chk($sformatf("halted_strobes%0d", i), 16'(strobes()), 16'(H));
            @(posedge clk);
            #1;
        end
        do_reset("halted");
        run_instr("and_post_halt", 3'd3, 1'b0, 8, IP, R, R, R | LA);

`ifdef CTRL_SINGLE_STEP_EN
        bus.step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("step_wait_phase%0d", i), 16'(bus.phase), 16'd0);
            chk($sformatf("step_wait_strobes%0d", i), 16'(strobes()), 16'(S));
            @(posedge clk);
            #1;
        end
        bus.step = 1'b1;
        @(posedge clk);
        #1;
        bus.step = 1'b0;
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("step_run_phase%0d", i), 16'(bus.phase), 16'(i));
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("step_rewait_phase%0d", i), 16'(bus.phase), 16'd0);
            @(posedge clk);
            #1;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
